audio_adc_rx: RTL and testbench

- I2S capture path from the audio codec ADC into the Nios II system; the receive-direction counterpart of the DAC serializer behind the audio_out conduit.
- FPGA is slave: codec drives BCLK and ADCLRCK, and the block samples ADCDAT.
- Assembles left/right words into stereo frames and buffers them in a small FIFO.
- Presents frames on a valid/ready stream to the audio DMA/CPU bridge; overflow is reported as a sticky flag.

---
 rtl/audio_rx_pkg.sv | 17 +
 rtl/audio_rx_fifo.sv | 63 ++++++
 rtl/audio_adc_rx.sv | 167 ++++++++++++++++
 tb/tb_audio_adc_rx.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_rx_pkg.sv
// Shared types and helpers for the I2S ADC receive path.
package audio_rx_pkg;

  typedef enum logic [1:0] {
    SYNC  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } rx_state_e;

  localparam logic LRCK_LEFT = 1'b0;

  // Width needed to hold a level of 0..depth frames.
  function automatic int level_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/audio_rx_fifo.sv
// Show-ahead stereo frame FIFO; the head output holds the last popped
// entry once the FIFO runs empty.
module audio_rx_fifo
  import audio_rx_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  localparam int LW = level_width(DEPTH),
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty,
  output logic [LW-1:0]    level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [LW-1:0]    count;
  logic [WIDTH-1:0] last_q;
  logic             do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == LW'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push = push & (~full | do_pop);

  // NOTE: the storage array is reset too, so the head output is a defined
  // zero straight out of reset rather than whatever the RAM powered up with.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      last_q <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        last_q <= mem[rd_ptr];
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + LW'(1);
        2'b01:   count <= count - LW'(1);
        default: count <= count;
      endcase
    end
  end

  assign head_data = empty ? last_q : mem[rd_ptr];
  assign level     = count;

endmodule

// File: rtl/audio_adc_rx.sv
// I2S slave receiver: synchronizes the codec clocks, deserializes left/right
// words, pairs them into stereo frames and queues them on a valid/ready stream.
module audio_adc_rx
  import audio_rx_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic                                enable,
  input  logic                                audio_in_BCLK,
  input  logic                                audio_in_ADCLRCK,
  input  logic                                audio_in_ADCDAT,
  output logic [DATA_WIDTH-1:0]               out_left_data,
  output logic [DATA_WIDTH-1:0]               out_right_data,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [level_width(FIFO_DEPTH)-1:0]  fifo_level,
  output logic                                overflow,
  input  logic                                clear_overflow
);

  localparam int CW = $clog2(DATA_WIDTH);

  logic [SYNC_STAGES-1:0] bclk_sync, lrck_sync, dat_sync;
  logic                   bclk_s, lrck_s, dat_s;
  logic                   bclk_prev, lrck_last;
  logic                   bclk_rise, lrck_edge;

  rx_state_e              state, next_state;
  logic                   start_word, shift_bit, word_done, abort;
  logic [CW-1:0]          bit_cnt;
  logic [DATA_WIDTH-2:0]  shift_reg;
  logic [DATA_WIDTH-1:0]  word_in, left_word, right_word;
  logic                   side, left_ok, push_q;

  logic [2*DATA_WIDTH-1:0] head;
  logic                    fifo_full, fifo_empty, pop, drop;

  // NOTE: every clocked register here uses non-blocking assignment so all
  // stages of the synchronizer chain sample the pre-edge value together.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bclk_sync <= '0;
      lrck_sync <= '0;
      dat_sync  <= '0;
    end else begin
      bclk_sync <= {bclk_sync[SYNC_STAGES-2:0], audio_in_BCLK};
      lrck_sync <= {lrck_sync[SYNC_STAGES-2:0], audio_in_ADCLRCK};
      dat_sync  <= {dat_sync[SYNC_STAGES-2:0],  audio_in_ADCDAT};
    end
  end

  assign bclk_s    = bclk_sync[SYNC_STAGES-1];
  assign lrck_s    = lrck_sync[SYNC_STAGES-1];
  assign dat_s     = dat_sync[SYNC_STAGES-1];
  assign bclk_rise = bclk_s & ~bclk_prev;
  assign lrck_edge = bclk_rise & (lrck_s ^ lrck_last);
  assign word_in   = {shift_reg, dat_s};
  assign word_done = shift_bit && (bit_cnt == CW'(DATA_WIDTH - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= SYNC;
    else          state <= next_state;
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    next_state = state;
    start_word = 1'b0;
    shift_bit  = 1'b0;
    abort      = 1'b0;
    if (!enable) begin
      next_state = SYNC;
      abort      = 1'b1;
    end else begin
      case (state)
        SYNC, HOLD: begin
          if (lrck_edge) begin
            next_state = SHIFT;
            start_word = 1'b1;
          end
        end
        SHIFT: begin
          // The edge bit is the I2S delay bit of the new word, never data.
          if (lrck_edge) begin
            start_word = 1'b1;
            abort      = 1'b1;
          end else if (bclk_rise) begin
            shift_bit = 1'b1;
            if (bit_cnt == CW'(DATA_WIDTH - 1)) next_state = HOLD;
          end
        end
        default: next_state = SYNC;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bclk_prev  <= 1'b0;
      lrck_last  <= 1'b0;
      bit_cnt    <= '0;
      shift_reg  <= '0;
      side       <= LRCK_LEFT;
      left_word  <= '0;
      right_word <= '0;
      left_ok    <= 1'b0;
      push_q     <= 1'b0;
    end else begin
      bclk_prev <= bclk_s;
      push_q    <= 1'b0;
      if (bclk_rise) lrck_last <= lrck_s;
      if (start_word) begin
        bit_cnt <= '0;
        side    <= lrck_s;
      end else if (shift_bit) begin
        shift_reg <= word_in[DATA_WIDTH-2:0];
        bit_cnt   <= bit_cnt + CW'(1);
      end
      if (abort) left_ok <= 1'b0;
      if (word_done) begin
        if (side == LRCK_LEFT) begin
          left_word <= word_in;
          left_ok   <= 1'b1;
        end else begin
          // A right word only forms a frame when its left partner is intact.
          right_word <= word_in;
          push_q     <= left_ok;
          left_ok    <= 1'b0;
        end
      end
    end
  end

  assign pop  = out_valid & out_ready;
  assign drop = push_q & fifo_full & ~pop;

  audio_rx_fifo #(
    .WIDTH (2 * DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push_q),
    .push_data ({left_word, right_word}),
    .pop       (pop),
    .head_data (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  assign out_valid      = ~fifo_empty;
  assign out_left_data  = head[2*DATA_WIDTH-1 -: DATA_WIDTH];
  assign out_right_data = head[DATA_WIDTH-1:0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)            overflow <= 1'b0;
    else if (drop)           overflow <= 1'b1;
    else if (clear_overflow) overflow <= 1'b0;
  end

endmodule

// File: tb/tb_audio_adc_rx.sv
// Bench for audio_adc_rx: acts as the I2S codec (BCLK = clk/16) and checks
// popped frames against a word-level model of the frame-pairing rules.
module tb_audio_adc_rx;

  localparam int DW    = 16;
  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          enable = 1'b0;
  logic          bclk = 1'b0;
  logic          lrck = 1'b0;
  logic          adcdat = 1'b0;
  logic          out_ready = 1'b0;
  logic          clear_overflow = 1'b0;
  logic [DW-1:0] out_left_data, out_right_data;
  logic          out_valid;
  logic [LW-1:0] fifo_level;
  logic          overflow;

  int                n_checks = 0;
  int                n_errors = 0;
  logic [2*DW-1:0]   exp_q[$];
  logic [2*DW-1:0]   lat_exp;
  logic              cur_lrck = 1'b0;
  bit                rand_ready = 1'b0;
  logic              model_left_ok = 1'b0;
  logic [DW-1:0]     model_left = '0;

  typedef struct {
    logic [DW-1:0] l;
    logic [DW-1:0] r;
    int            l_len;
    int            r_len;
    bit            exp_frame;
  } vec_t;
  vec_t vecs[8];

  audio_adc_rx #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .SYNC_STAGES(2)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .enable           (enable),
    .audio_in_BCLK    (bclk),
    .audio_in_ADCLRCK (lrck),
    .audio_in_ADCDAT  (adcdat),
    .out_left_data    (out_left_data),
    .out_right_data   (out_right_data),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .fifo_level       (fifo_level),
    .overflow         (overflow),
    .clear_overflow   (clear_overflow)
  );

  always #10 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Consumer side: every accepted frame must be the oldest expected one.
  always @(negedge clk) begin
    #1;
    if (reset_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL pop_unexpected: got %h expected no frame", {out_left_data, out_right_data});
      end else begin
        check("pop_frame", {out_left_data, out_right_data}, exp_q.pop_front());
      end
    end
  end

  task automatic drive_bit(input logic l, input logic d);
    bclk = 1'b0;
    lrck = l;
    adcdat = d;
    cur_lrck = l;
    if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    repeat (8) @(negedge clk);
    bclk = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  // Final bit with cycle-exact checks around the completion and push edges.
  task automatic last_bit_special(input logic l, input logic d, input int mode);
    bclk = 1'b0;
    lrck = l;
    adcdat = d;
    cur_lrck = l;
    repeat (8) @(negedge clk);
    bclk = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    if (mode == 1) check("lat_before_push", out_valid, 1'b0);
    if (mode == 2) out_ready = 1'b1;
    @(posedge clk);
    #1;
    if (mode == 1) begin
      check("lat_valid", out_valid, 1'b1);
      check("lat_frame", {out_left_data, out_right_data}, lat_exp);
    end
    if (mode == 2) begin
      out_ready = 1'b0;
      check("fullpop_level", fifo_level, 4);
      check("fullpop_no_ovf", overflow, 1'b0);
    end
    @(posedge clk);
    #1;
    if (mode == 1) check("lat_one_cycle", out_valid, 1'b0);
    repeat (5) @(negedge clk);
  endtask

  // One I2S word: delay bit, then nbits data bits MSB first (extra bits padded).
  task automatic send_word(input logic side, input logic [DW-1:0] data, input int nbits,
                           input int mode);
    drive_bit(side, 1'($urandom));
    for (int i = 0; i < nbits; i++) begin
      logic b;
      b = (i < DW) ? data[DW-1-i] : 1'($urandom);
      if (mode != 0 && i == nbits - 1) last_bit_special(side, b, mode);
      else drive_bit(side, b);
    end
  endtask

  // Word-level pairing rules: complete left arms, complete right after an
  // armed left emits a frame, any short word disarms.
  task automatic model_word(input logic side, input logic [DW-1:0] data, input int nbits);
    if (nbits < DW) begin
      model_left_ok = 1'b0;
    end else if (side == 1'b0) begin
      model_left = data;
      model_left_ok = 1'b1;
    end else begin
      if (model_left_ok) exp_q.push_back({model_left, data});
      model_left_ok = 1'b0;
    end
  endtask

  task automatic send_pair(input logic [DW-1:0] l, input logic [DW-1:0] r);
    send_word(1'b0, l, DW, 0);
    send_word(1'b1, r, DW, 0);
  endtask

  initial begin
    vecs[0] = '{16'hBEEF, 16'hCAFE, 16, 16, 1'b1};
    vecs[1] = '{16'h0000, 16'hFFFF, 16, 16, 1'b1};
    vecs[2] = '{16'hFFFF, 16'h0000, 18, 16, 1'b1};
    vecs[3] = '{16'h8001, 16'h7FFE, 16, 20, 1'b1};
    vecs[4] = '{16'h1357, 16'h2468, 10, 16, 1'b0};
    vecs[5] = '{16'h1111, 16'h2222, 16, 16, 1'b1};
    vecs[6] = '{16'hAAAA, 16'h5555, 16,  9, 1'b0};
    vecs[7] = '{16'h3C3C, 16'hC3C3, 16, 16, 1'b1};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_valid", out_valid, 1'b0);
    check("rst_level", fifo_level, 0);
    check("rst_overflow", overflow, 1'b0);
    check("rst_data", {out_left_data, out_right_data}, 0);
    reset_n = 1'b1;
    enable = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);

    // Basic frame with latency check; the priming right word has no partner
    send_word(1'b1, 16'h9999, DW, 0);
    check("prime_drop_level", fifo_level, 0);
    lat_exp = {16'hA5C3, 16'h1234};
    exp_q.push_back(lat_exp);
    send_word(1'b0, 16'hA5C3, DW, 0);
    send_word(1'b1, 16'h1234, DW, 1);
    check("basic_drained", exp_q.size(), 0);
    check("basic_no_ovf", overflow, 1'b0);

    // Table of L/R pairs including short left and short right words
    for (int k = 0; k < 8; k++) begin
      if (vecs[k].exp_frame) exp_q.push_back({vecs[k].l, vecs[k].r});
      send_word(1'b0, vecs[k].l, vecs[k].l_len, 0);
      send_word(1'b1, vecs[k].r, vecs[k].r_len, 0);
      check($sformatf("tbl%0d_drained", k), exp_q.size(), 0);
    end
    check("tbl_no_ovf", overflow, 1'b0);

    // Startup mid-frame: enable rises partway through a left word
    enable = 1'b0;
    send_word(1'b1, 16'h7777, DW, 0);
    drive_bit(1'b0, 1'b0);
    for (int i = 0; i < 6; i++) drive_bit(1'b0, 1'b1);
    enable = 1'b1;
    for (int i = 0; i < 10; i++) drive_bit(1'b0, 1'b1);
    send_word(1'b1, 16'hDEAD, DW, 0);
    check("startup_drop_level", fifo_level, 0);
    check("startup_drop_valid", out_valid, 1'b0);
    exp_q.push_back({16'h0A0A, 16'h0B0B});
    exp_q.push_back({16'h0C0C, 16'h0D0D});
    send_pair(16'h0A0A, 16'h0B0B);
    send_pair(16'h0C0C, 16'h0D0D);
    check("startup_drained", exp_q.size(), 0);
    check("startup_no_ovf", overflow, 1'b0);

    // Overflow: five frames into a four-deep FIFO with no consumer
    out_ready = 1'b0;
    for (int f = 1; f <= 5; f++) begin
      if (f <= 4) exp_q.push_back({16'(f), 16'(16'h0100 + f)});
      send_pair(16'(f), 16'(16'h0100 + f));
    end
    check("ovf_level", fifo_level, 4);
    check("ovf_flag", overflow, 1'b1);
    check("ovf_valid", out_valid, 1'b1);
    @(negedge clk);
    out_ready = 1'b1;
    repeat (10) @(negedge clk);
    check("ovf_drained", exp_q.size(), 0);
    check("ovf_empty_level", fifo_level, 0);
    check("ovf_hold_data", {out_left_data, out_right_data}, {16'h0004, 16'h0104});
    check("ovf_sticky", overflow, 1'b1);
    clear_overflow = 1'b1;
    @(negedge clk);
    clear_overflow = 1'b0;
    #1;
    check("ovf_cleared", overflow, 1'b0);

    // Full FIFO with a pop in the same cycle as the push
    out_ready = 1'b0;
    for (int f = 1; f <= 4; f++) begin
      exp_q.push_back({16'(16'h0010 + f), 16'(16'h0110 + f)});
      send_pair(16'(16'h0010 + f), 16'(16'h0110 + f));
    end
    check("fullpop_pre_level", fifo_level, 4);
    exp_q.push_back({16'h0015, 16'h0115});
    send_word(1'b0, 16'h0015, DW, 0);
    send_word(1'b1, 16'h0115, DW, 2);
    out_ready = 1'b1;
    repeat (10) @(negedge clk);
    check("fullpop_drained", exp_q.size(), 0);
    check("fullpop_ovf_after", overflow, 1'b0);

    // Asynchronous reset during bit 7 of a left word
    out_ready = 1'b0;
    send_pair(16'h0021, 16'h0121);
    check("arst_pre_valid", out_valid, 1'b1);
    drive_bit(1'b0, 1'b0);
    for (int i = 0; i < 6; i++) drive_bit(1'b0, 1'b1);
    bclk = 1'b0;
    adcdat = 1'b1;
    repeat (3) @(negedge clk);
    #3 reset_n = 1'b0;
    #1;
    check("arst_valid", out_valid, 1'b0);
    check("arst_level", fifo_level, 0);
    check("arst_data", {out_left_data, out_right_data}, 0);
    #20 reset_n = 1'b1;
    out_ready = 1'b1;
    repeat (4) @(negedge clk);
    bclk = 1'b1;
    repeat (8) @(negedge clk);
    for (int i = 0; i < 9; i++) drive_bit(1'b0, 1'b0);
    send_word(1'b1, 16'h0333, DW, 0);
    check("arst_drop_level", fifo_level, 0);
    exp_q.push_back({16'h0031, 16'h0131});
    send_pair(16'h0031, 16'h0131);
    check("arst_drained", exp_q.size(), 0);

    // Randomized words against the pairing model, random consumer stalls
    model_left_ok = 1'b0;
    rand_ready = 1'b1;
    for (int k = 0; k < 30; k++) begin
      logic          side;
      logic [DW-1:0] data;
      int            len;
      side = ~cur_lrck;
      data = DW'($urandom);
      case ($urandom_range(0, 3))
        0, 1:    len = DW;
        2:       len = $urandom_range(DW + 1, DW + 4);
        default: len = $urandom_range(0, DW - 1);
      endcase
      model_word(side, data, len);
      send_word(side, data, len, 0);
    end
    rand_ready = 1'b0;
    out_ready = 1'b1;
    repeat (20) @(negedge clk);
    check("rand_drained", exp_q.size(), 0);
    check("rand_no_ovf", overflow, 1'b0);
    check("rand_empty", out_valid, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
